// File: rtl/matrix_pkg.sv
// Shared constants, glyph table and helpers for the LED matrix scan decoder.
package matrix_pkg;

  localparam int NUM_COLS = 7;
  localparam int NUM_ROWS = 5;
  localparam int FRAME_W  = 35;

  // Glyphs in frame_data packing {col0, col1, ..., col6}; bit 4 of each column is row 1.
  localparam logic [FRAME_W-1:0] GLYPH_0 = {5'b00000, 5'b01110, 5'b10001, 5'b10001,
                                            5'b10001, 5'b01110, 5'b00000};
  localparam logic [FRAME_W-1:0] GLYPH_1 = {5'b00000, 5'b00000, 5'b01001, 5'b11111,
                                            5'b00001, 5'b00000, 5'b00000};
  localparam logic [FRAME_W-1:0] GLYPH_2 = {5'b00000, 5'b01001, 5'b10011, 5'b10101,
                                            5'b10101, 5'b01001, 5'b00000};
  localparam logic [FRAME_W-1:0] GLYPH_3 = {5'b00000, 5'b10001, 5'b10101, 5'b10101,
                                            5'b10101, 5'b01010, 5'b00000};

  typedef enum logic [1:0] {HUNT, COLLECT, DONE} state_t;

  // Column strobe bit 6 is column 0, bit 0 is column 6.
  function automatic logic [2:0] col_onehot_to_idx(input logic [NUM_COLS-1:0] col);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_COLS; i++)
      if (col[i]) idx = 3'(NUM_COLS - 1 - i);
    return idx;
  endfunction

  function automatic logic is_onehot(input logic [NUM_COLS-1:0] col);
    return (col != '0) && ((col & (col - 7'd1)) == '0);
  endfunction

endpackage

// File: rtl/matrix_glyph_match.sv
// Combinational compare of a captured frame against the glyph table; lowest code wins.
module matrix_glyph_match
  import matrix_pkg::*;
(
  input  logic [FRAME_W-1:0] frame,
  output logic               hit,
  output logic [1:0]         code
);

  // Priority chain so a duplicated glyph resolves to the lowest code.
  always_comb begin
    hit  = 1'b1;
    code = 2'd0;
    if      (frame == GLYPH_0) code = 2'd0;
    else if (frame == GLYPH_1) code = 2'd1;
    else if (frame == GLYPH_2) code = 2'd2;
    else if (frame == GLYPH_3) code = 2'd3;
    else                       hit  = 1'b0;
  end

endmodule

// File: rtl/matrix_frame_decoder.sv
// Scan-interface monitor: rebuilds 7x5 frames from the column strobe and rows,
// matches them against the glyph table and locks a character code.
module matrix_frame_decoder
  import matrix_pkg::*;
#(
  parameter int SETTLE_CYC    = 1,
  parameter int TIMEOUT_CYC   = 1023,
  parameter int STABLE_FRAMES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_COLS-1:0] col_in,
  input  logic [NUM_ROWS-1:0] row_in,
  output logic [FRAME_W-1:0]  frame_data,
  output logic                frame_done,
  output logic                frame_match,
  output logic [1:0]          char_code,
  output logic                char_valid,
  output logic                proto_err
);

  localparam logic [4:0]  SETTLE_V = 5'(SETTLE_CYC);
  localparam logic [15:0] TMO_V    = 16'(TIMEOUT_CYC);
  localparam logic [2:0]  STABLE_V = 3'(STABLE_FRAMES);

  logic [NUM_COLS-1:0] col_r, col_last;
  logic [NUM_ROWS-1:0] row_r;
  logic [4:0]          settle_cnt, settle_nxt;
  logic [15:0]         idle_cnt;
  state_t              state, state_nxt;
  logic [2:0]          exp_col, exp_col_nxt, col_idx;
  logic [FRAME_W-1:0]  frame_buf;
  logic                col_new, col_bad, col_latch, timeout;
  logic                store, err_nxt, emit;
  logic                g_hit;
  logic [1:0]          g_code, cand_code, prev_code;
  logic [2:0]          run_cnt, run_nxt;

  // Input register stage; col_last lets us see a change of the registered column.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_r    <= '0;
      row_r    <= '0;
      col_last <= '0;
    end else begin
      col_r    <= col_in;
      row_r    <= row_in;
      col_last <= col_r;
    end
  end

  assign col_new   = (col_r != col_last);
  assign col_idx   = col_onehot_to_idx(col_r);
  // Multi-hot is flagged once per occurrence; all-zero is blanking.
  assign col_bad   = col_new && (col_r != '0) && !is_onehot(col_r);
  // Counter saturates above SETTLE so each column occurrence latches exactly once.
  assign settle_nxt = col_new ? 5'd1 : ((settle_cnt > SETTLE_V) ? settle_cnt : settle_cnt + 5'd1);
  assign col_latch  = is_onehot(col_r) && (settle_nxt == SETTLE_V);
  assign timeout    = (state == COLLECT) && !col_new && (idle_cnt == TMO_V - 16'd1);

  // Settle and idle counters restart on every registered column change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_cnt <= '0;
      idle_cnt   <= '0;
    end else begin
      settle_cnt <= settle_nxt;
      if (col_new)                idle_cnt <= '0;
      else if (idle_cnt != TMO_V) idle_cnt <= idle_cnt + 16'd1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= HUNT;
      exp_col <= '0;
    end else begin
      state   <= state_nxt;
      exp_col <= exp_col_nxt;
    end
  end

  // Next-state: column sequencing, error detection and frame completion.
  always_comb begin
    state_nxt   = state;
    exp_col_nxt = exp_col;
    store       = 1'b0;
    err_nxt     = col_bad;
    emit        = (state == DONE);
    unique case (state)
      HUNT: begin
        if (col_latch && col_idx == 3'd0) begin
          store = 1'b1; exp_col_nxt = 3'd1; state_nxt = COLLECT;
        end
      end
      COLLECT: begin
        if (timeout) begin
          err_nxt = 1'b1; state_nxt = HUNT;
        end else if (col_latch) begin
          if (col_idx == exp_col) begin
            store       = 1'b1;
            exp_col_nxt = exp_col + 3'd1;
            if (col_idx == 3'd6) state_nxt = DONE;
          end else begin
            err_nxt = 1'b1;
            if (col_idx == 3'd0) begin
              store = 1'b1; exp_col_nxt = 3'd1;
            end else begin
              state_nxt = HUNT;
            end
          end
        end
      end
      DONE: begin
        // A column 0 latched right behind column 6 starts the next frame directly.
        if (col_latch && col_idx == 3'd0) begin
          store = 1'b1; exp_col_nxt = 3'd1; state_nxt = COLLECT;
        end else begin
          state_nxt = HUNT;
        end
      end
      default: state_nxt = HUNT;
    endcase
    if (col_bad) state_nxt = HUNT;
  end

  // Frame buffer: one 5-bit slot per column, column 0 in the top bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_buf <= '0;
    end else begin
      for (int i = 0; i < NUM_COLS; i++)
        if (store && col_idx == 3'(i))
          frame_buf[NUM_ROWS*(NUM_COLS-1-i) +: NUM_ROWS] <= row_r;
    end
  end

  matrix_glyph_match u_glyph (
    .frame (frame_buf),
    .hit   (g_hit),
    .code  (g_code)
  );

  // Frame outputs and error pulse; frame_data only moves on a completed frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_data  <= '0;
      frame_done  <= 1'b0;
      frame_match <= 1'b0;
      cand_code   <= '0;
      proto_err   <= 1'b0;
    end else begin
      proto_err   <= err_nxt;
      frame_done  <= emit;
      frame_match <= emit & g_hit;
      if (emit) begin
        frame_data <= frame_buf;
        cand_code  <= g_code;
      end
    end
  end

  // Run length of identical matching frames, saturating at STABLE_FRAMES.
  always_comb begin
    run_nxt = 3'd1;
    if (cand_code == prev_code)
      run_nxt = (run_cnt >= STABLE_V) ? STABLE_V : run_cnt + 3'd1;
  end

  // Character lock, evaluated the cycle after each frame_done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_cnt    <= '0;
      prev_code  <= '0;
      char_code  <= '0;
      char_valid <= 1'b0;
    end else if (frame_done) begin
      if (frame_match) begin
        run_cnt   <= run_nxt;
        prev_code <= cand_code;
        if (run_nxt == STABLE_V) begin
          char_code  <= cand_code;
          char_valid <= 1'b1;
        end
      end else begin
        run_cnt    <= '0;
        char_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_matrix_frame_decoder.sv
// Randomized bench for matrix_frame_decoder with an event-level reference model.
module tb_matrix_frame_decoder;
  import matrix_pkg::*;

  localparam int SETTLE  = 1;
  localparam int TMO     = 1023;
  localparam int STABLE  = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  col_in = '0;
  logic [4:0]  row_in = '0;
  logic [34:0] frame_data;
  logic        frame_done, frame_match, char_valid, proto_err;
  logic [1:0]  char_code;

  matrix_frame_decoder #(.SETTLE_CYC(SETTLE), .TIMEOUT_CYC(TMO), .STABLE_FRAMES(STABLE)) dut (
    .clk(clk), .rst_n(rst_n), .col_in(col_in), .row_in(row_in),
    .frame_data(frame_data), .frame_done(frame_done), .frame_match(frame_match),
    .char_code(char_code), .char_valid(char_valid), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, ncyc = 0;
  int done_q[$], perr_q[$];
  int match_cnt = 0, valid_drop = 0;
  bit mon_valid = 0;

  // Reference model state (plain integers and arrays).
  logic [6:0]  m_prev_c, m_pend_c;
  logic [4:0]  m_pend_r;
  int          m_run, m_u, m_mode, m_exp, m_lrun;
  logic [4:0]  m_buf [7];
  logic [1:0]  m_prevcode, e_cand, e_code;
  logic [34:0] e_data;
  logic        e_done, e_match, e_err, e_valid;

  task automatic chk(input string nm, input logic [34:0] act, input logic [34:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 30) $display("FAIL %s actual=%h expected=%h cyc=%0d", nm, act, exp, ncyc);
    end
  endtask

  task automatic model_reset();
    m_prev_c = '0; m_pend_c = '0; m_pend_r = '0;
    m_run = 0; m_u = 0; m_mode = 0; m_exp = 0; m_lrun = 0;
    for (int i = 0; i < 7; i++) m_buf[i] = '0;
    m_prevcode = '0; e_cand = '0; e_code = '0; e_data = '0;
    e_done = 0; e_match = 0; e_err = 0; e_valid = 0;
  endtask

  // Decide one cycle's worth of events for a registered column/row sample.
  task automatic decide(input logic [6:0] c, input logic [4:0] r);
    bit chg, oh, bad, lat, tmo;
    int idx;
    logic [34:0] f;
    chg = (c != m_prev_c);
    m_prev_c = c;
    m_run = chg ? 1 : (m_run < 100 ? m_run + 1 : m_run);
    m_u   = chg ? 0 : (m_u < 70000 ? m_u + 1 : m_u);
    oh  = ($countones(c) == 1);
    idx = 0;
    for (int b = 0; b < 7; b++) if (c[b]) idx = 6 - b;
    bad = chg && (c != 0) && !oh;
    lat = oh && (m_run == SETTLE);
    tmo = (m_mode == 1) && (m_u == TMO);
    e_done = 0; e_match = 0; e_err = bad || tmo;
    if (m_mode == 2) begin
      f = '0;
      for (int i = 0; i < 7; i++) f = {f[29:0], m_buf[i]};
      e_done = 1; e_data = f; e_cand = 2'd0;
      if      (f == GLYPH_0) begin e_match = 1; e_cand = 2'd0; end
      else if (f == GLYPH_1) begin e_match = 1; e_cand = 2'd1; end
      else if (f == GLYPH_2) begin e_match = 1; e_cand = 2'd2; end
      else if (f == GLYPH_3) begin e_match = 1; e_cand = 2'd3; end
    end
    case (m_mode)
      0: if (lat && idx == 0) begin m_buf[0] = r; m_exp = 1; m_mode = 1; end
      1: begin
        if (tmo) m_mode = 0;
        else if (lat) begin
          if (idx == m_exp) begin
            m_buf[idx] = r; m_exp++;
            if (idx == 6) m_mode = 2;
          end else begin
            e_err = 1;
            if (idx == 0) begin m_buf[0] = r; m_exp = 1; end
            else m_mode = 0;
          end
        end
      end
      default: begin
        if (lat && idx == 0) begin m_buf[0] = r; m_exp = 1; m_mode = 1; end
        else m_mode = 0;
      end
    endcase
    if (bad) m_mode = 0;
  endtask

  // One clock edge: lock stage on the previously visible frame, then the new decision.
  task automatic model_step(input logic [6:0] c, input logic [4:0] r);
    if (e_done) begin
      if (e_match) begin
        if (e_cand == m_prevcode) m_lrun = (m_lrun >= STABLE) ? STABLE : m_lrun + 1;
        else m_lrun = 1;
        m_prevcode = e_cand;
        if (m_lrun == STABLE) begin e_code = e_cand; e_valid = 1; end
      end else begin
        m_lrun = 0; e_valid = 0;
      end
    end
    decide(m_pend_c, m_pend_r);
    m_pend_c = c; m_pend_r = r;
  endtask

  task automatic compare();
    chk("frame_data", frame_data, e_data);
    chk("frame_done", 35'(frame_done), 35'(e_done));
    chk("frame_match", 35'(frame_match), 35'(e_match));
    chk("char_code", 35'(char_code), 35'(e_code));
    chk("char_valid", 35'(char_valid), 35'(e_valid));
    chk("proto_err", 35'(proto_err), 35'(e_err));
    if (frame_done) done_q.push_back(ncyc);
    if (proto_err) perr_q.push_back(ncyc);
    if (frame_match) match_cnt++;
    if (mon_valid && !char_valid) valid_drop++;
  endtask

  task automatic drive_step(input logic [6:0] c, input logic [4:0] r);
    col_in = c; row_in = r;
    @(posedge clk);
    model_step(c, r);
  endtask

  task automatic cyc(input logic [6:0] c, input logic [4:0] r);
    ncyc++;
    @(negedge clk);
    compare();
    drive_step(c, r);
  endtask

  function automatic logic [6:0] colv(input int idx);
    logic [6:0] v;
    v = 7'b1000000;
    return v >> idx;
  endfunction

  function automatic logic [4:0] gcol(input logic [34:0] g, input int idx);
    return g[34-5*idx -: 5];
  endfunction

  function automatic logic [6:0] bad_col();
    logic [6:0] v;
    do v = 7'($urandom_range(1, 127)); while ($countones(v) < 2);
    return v;
  endfunction

  task automatic scan(input logic [34:0] g, input int dwell);
    for (int i = 0; i < 7; i++) repeat (dwell) cyc(colv(i), gcol(g, i));
  endtask

  task automatic blank(input int n);
    repeat (n) cyc(7'd0, 5'd0);
  endtask

  task automatic clrq();
    done_q.delete(); perr_q.delete(); match_cnt = 0;
  endtask

  task automatic check_reset_zero(input string tag);
    chk({tag, "_data"}, frame_data, 35'h0);
    chk({tag, "_done"}, 35'(frame_done), 35'h0);
    chk({tag, "_match"}, 35'(frame_match), 35'h0);
    chk({tag, "_code"}, 35'(char_code), 35'h0);
    chk({tag, "_valid"}, 35'(char_valid), 35'h0);
    chk({tag, "_err"}, 35'(proto_err), 35'h0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    logic [34:0] g;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_zero("rst");
    rst_n = 1'b1;
    drive_step(7'd0, 5'd0);
    blank(3);

    // Three clean GLYPH_2 frames, dwell 3.
    clrq();
    repeat (3) scan(GLYPH_2, 3);
    blank(4);
    chk("g2_done_cnt", 35'(done_q.size()), 35'd3);
    if (done_q.size() == 3) begin
      chk("g2_spacing1", 35'(done_q[1] - done_q[0]), 35'd21);
      chk("g2_spacing2", 35'(done_q[2] - done_q[1]), 35'd21);
    end
    chk("g2_match_cnt", 35'(match_cnt), 35'd3);
    chk("g2_code", 35'(char_code), 35'(2'b10));
    chk("g2_valid", 35'(char_valid), 35'd1);
    chk("g2_data", frame_data, GLYPH_2);

    // Switch to GLYPH_1: code changes only after the second GLYPH_1 frame.
    mon_valid = 1;
    scan(GLYPH_1, 3); blank(4);
    chk("g1a_code", 35'(char_code), 35'(2'b10));
    scan(GLYPH_1, 3); blank(4);
    chk("g1b_code", 35'(char_code), 35'(2'b01));
    mon_valid = 0;
    chk("g1_valid_drop", 35'(valid_drop), 35'd0);

    // Illegal multi-hot column in place of column 3.
    clrq();
    for (int i = 0; i < 7; i++)
      repeat (3) cyc((i == 3) ? 7'b0110000 : colv(i), gcol(GLYPH_2, i));
    scan(GLYPH_2, 3); blank(4);
    chk("ill_err_cnt", 35'(perr_q.size()), 35'd1);
    chk("ill_done_cnt", 35'(done_q.size()), 35'd1);

    // Out-of-order sequence 0,1,3.
    clrq();
    for (int i = 0; i < 7; i++)
      if (i != 2) repeat (3) cyc(colv(i), gcol(GLYPH_2, i));
    scan(GLYPH_2, 3); blank(4);
    chk("skip_err_cnt", 35'(perr_q.size()), 35'd1);
    chk("skip_done_cnt", 35'(done_q.size()), 35'd1);

    // Two all-zero frames clear the lock but keep the code.
    clrq();
    repeat (2) scan(35'h0, 3);
    blank(4);
    chk("zero_done_cnt", 35'(done_q.size()), 35'd2);
    chk("zero_match_cnt", 35'(match_cnt), 35'd0);
    chk("zero_data", frame_data, 35'h0);
    chk("zero_valid", 35'(char_valid), 35'd0);
    chk("zero_code", 35'(char_code), 35'(2'b10));

    // Randomized frames with blanking, illegal columns and skips.
    for (int f = 0; f < 150; f++) begin
      g = ($urandom_range(0, 9) < 7) ?
          ((f % 4 == 0) ? GLYPH_0 : (f % 4 == 1) ? GLYPH_1 : (f % 4 == 2) ? GLYPH_2 : GLYPH_3) :
          {3'($urandom), $urandom};
      if ($urandom_range(0, 3) == 0) g = (($urandom_range(0, 1) == 0) ? GLYPH_3 : GLYPH_0);
      for (int i = 0; i < 7; i++) begin
        int d;
        d = $urandom_range(1, 4);
        if ($urandom_range(0, 99) < 3) continue;
        if ($urandom_range(0, 99) < 10) blank($urandom_range(1, 2));
        if ($urandom_range(0, 99) < 3) begin
          repeat (d) cyc(bad_col(), 5'($urandom));
        end else begin
          cyc(colv(i), gcol(g, i));
          for (int j = 1; j < d; j++)
            cyc(colv(i), ($urandom_range(0, 9) == 0) ? 5'($urandom) : gcol(g, i));
        end
      end
    end
    blank(4);

    // Lock GLYPH_3, then stall on column 4 until the timeout fires.
    repeat (2) scan(GLYPH_3, 3);
    blank(4);
    chk("g3_code", 35'(char_code), 35'(2'b11));
    chk("g3_valid", 35'(char_valid), 35'd1);
    clrq();
    for (int i = 0; i < 4; i++) repeat (3) cyc(colv(i), gcol(GLYPH_0, i));
    k = ncyc + 1;
    repeat (1100) cyc(colv(4), gcol(GLYPH_0, 4));
    chk("tmo_err_cnt", 35'(perr_q.size()), 35'd1);
    if (perr_q.size() == 1) chk("tmo_latency", 35'(perr_q[0] - k), 35'd1025);
    chk("tmo_done_cnt", 35'(done_q.size()), 35'd0);
    chk("tmo_valid_kept", 35'(char_valid), 35'd1);
    chk("tmo_data_kept", frame_data, GLYPH_3);

    // Asynchronous reset in the middle of a frame.
    for (int i = 0; i < 3; i++) repeat (2) cyc(colv(i), gcol(GLYPH_1, i));
    #2 rst_n = 1'b0;
    #1 check_reset_zero("arst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    drive_step(7'd0, 5'd0);
    clrq();
    repeat (2) scan(GLYPH_0, 2);
    blank(4);
    chk("post_rst_done", 35'(done_q.size()), 35'd2);
    chk("post_rst_code", 35'(char_code), 35'(2'b00));
    chk("post_rst_valid", 35'(char_valid), 35'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
